fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 154 +++++++++++++++
 tb/tb_fetch_stage.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage -- two-deep instruction fetch front end.
//
// Drives a PC to instruction memory, tracks the one request whose data is
// returning (f2 slot), and registers the instruction into the if_* outputs
// for decode. A skid register (hold_instr) catches the returning data on
// the first stall cycle, so nothing is lost while the PC is frozen.
//
// Ports
//   clk          : clock, all state on rising edge
//   reset        : synchronous, active-high
//   instr_addr   : fetch address (== pc, combinational)
//   instr_in     : memory read data, one cycle after its address
//   stall        : decode cannot take the current if_* output
//   redirect     : taken branch/jump, redirect_pc is the new target
//   redirect_pc  : redirect target
//   if_valid/if_pc/if_instr/if_pc_plus4 : registered instruction to decode
//   halted       : fetch stopped after reaching PC 0
//   fetch_count  : instructions accepted by decode (wraps)
module fetch_stage #(
  parameter logic [31:0] pc_init = 32'h80020000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] instr_addr,
  input  logic [31:0] instr_in,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc_plus4,
  output logic        halted,
  output logic [31:0] fetch_count
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t      r_state, w_state_nxt;

  logic [31:0] r_pc;
  logic        r_f2_valid;
  logic [31:0] r_f2_pc;
  logic        r_hold_valid;
  logic [31:0] r_hold_instr;
  logic        r_if_valid;
  logic [31:0] r_if_pc;
  logic [31:0] r_if_instr;
  logic [31:0] r_if_pc_plus4;
  logic [31:0] r_fetch_count;

  logic        w_redir;
  logic        w_issue;
  logic        w_halt_now;

  // Halt FSM plus the per-cycle control decode. Redirect is ignored once
  // halted; issue happens only in RUN with a non-zero PC.
  always_comb begin
    w_state_nxt = r_state;
    w_redir     = 1'b0;
    w_issue     = 1'b0;
    w_halt_now  = 1'b0;
    case (r_state)
      ST_RUN: begin
        w_redir = redirect;
        if (!redirect && !stall) begin
          if (r_pc == 32'h0) begin
            w_halt_now  = 1'b1;
            w_state_nxt = ST_HALT;
          end else begin
            w_issue = 1'b1;
          end
        end
      end
      ST_HALT: begin
        w_state_nxt = ST_HALT;
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc          <= pc_init;
      r_f2_valid    <= 1'b0;
      r_f2_pc       <= 32'h0;
      r_hold_valid  <= 1'b0;
      r_hold_instr  <= 32'h0;
      r_if_valid    <= 1'b0;
      r_if_pc       <= 32'h0;
      r_if_instr    <= 32'h0;
      r_if_pc_plus4 <= 32'h0;
      r_fetch_count <= 32'h0;
    end else begin
      if (w_redir) begin
        // Flush everything younger than the delay slot; if_pc/if_instr
        // keep stale data but are qualified by if_valid.
        r_pc         <= redirect_pc;
        r_f2_valid   <= 1'b0;
        r_hold_valid <= 1'b0;
        r_if_valid   <= 1'b0;
      end else if (!stall) begin
        r_f2_valid <= w_issue;
        if (w_issue) begin
          r_f2_pc <= r_pc;
          r_pc    <= r_pc + 32'd4;
        end
        r_if_valid    <= r_f2_valid;
        r_if_pc       <= r_f2_pc;
        r_if_pc_plus4 <= r_f2_pc + 32'd4;
        // The skid copy wins: instr_in now carries data for the PC held
        // during the stall, not for f2.
        r_if_instr    <= r_hold_valid ? r_hold_instr : instr_in;
        r_hold_valid  <= 1'b0;
      end else begin
        // Only the first stall cycle sees f2's data on instr_in.
        if (r_f2_valid && !r_hold_valid) begin
          r_hold_instr <= instr_in;
          r_hold_valid <= 1'b1;
        end
      end

      if (r_if_valid && !stall) begin
        r_fetch_count <= r_fetch_count + 32'd1;
      end
    end
  end

  assign instr_addr  = r_pc;
  assign if_valid    = r_if_valid;
  assign if_pc       = r_if_pc;
  assign if_instr    = r_if_instr;
  assign if_pc_plus4 = r_if_pc_plus4;
  assign halted      = (r_state == ST_HALT);
  assign fetch_count = r_fetch_count;

  // w_halt_now is kept as a named decode term for debug visibility.
  logic w_unused;
  assign w_unused = w_halt_now;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed/random bench for fetch_stage with a behavioural instruction
// memory and a scoreboard of issued (pc, instr) pairs.
module tb_fetch_stage;

  localparam logic [31:0] PC0 = 32'h80020000;

  logic        clk;
  logic        reset;
  logic [31:0] instr_addr;
  logic [31:0] instr_in;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic [31:0] if_pc_plus4;
  logic        halted;
  logic [31:0] fetch_count;

  fetch_stage #(.pc_init(PC0)) dut (
    .clk(clk), .reset(reset), .instr_addr(instr_addr), .instr_in(instr_in),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .if_pc_plus4(if_pc_plus4), .halted(halted), .fetch_count(fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return a ^ {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  // one-cycle read latency memory
  always @(posedge clk) instr_in <= mem_f(instr_addr);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        sb[$];
  logic [31:0] exp_pc;
  logic [31:0] exp_cnt;
  logic        exp_halted;
  int          bubble;
  int          n_assert;
  int          n_fail;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a falling edge: drive inputs, check this cycle's outputs,
  // advance the model, then move to the next falling edge.
  task automatic step(input logic s, input logic r, input logic [31:0] rpc);
    ent_t e;
    stall       = s;
    redirect    = r;
    redirect_pc = rpc;
    chk("instr_addr", instr_addr, exp_pc);
    chk("halted", {31'b0, halted}, {31'b0, exp_halted});
    chk("fetch_count", fetch_count, exp_cnt);
    if (bubble > 0) begin
      chk("if_valid_bubble", {31'b0, if_valid}, 32'd0);
      bubble--;
    end
    if (exp_halted && sb.size() == 0)
      chk("if_valid_halted", {31'b0, if_valid}, 32'd0);
    if (if_valid === 1'b1 && !s) begin
      if (sb.size() == 0) begin
        chk("if_valid_unexpected", {31'b0, if_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("if_pc", if_pc, e.pc);
        chk("if_instr", if_instr, e.ins);
        chk("if_pc_plus4", if_pc_plus4, e.pc + 32'd4);
      end
      exp_cnt++;
    end
    if (r && !exp_halted) begin
      sb.delete();
      exp_pc = rpc;
      bubble = 2;
    end else if (!s && !exp_halted) begin
      if (exp_pc == 32'h0) begin
        exp_halted = 1'b1;
      end else begin
        sb.push_back('{exp_pc, mem_f(exp_pc)});
        exp_pc += 32'd4;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input logic s);
    reset    = 1'b1;
    stall    = s;
    redirect = 1'b1;
    redirect_pc = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_if_instr", if_instr, 32'd0);
    chk("rst_if_pc_plus4", if_pc_plus4, 32'd0);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    chk("rst_fetch_count", fetch_count, 32'd0);
    chk("rst_instr_addr", instr_addr, PC0);
    reset      = 1'b0;
    sb.delete();
    exp_pc     = PC0;
    exp_cnt    = 32'd0;
    exp_halted = 1'b0;
    bubble     = 0;
  endtask

  task automatic basic_seq();
    step(0, 0, 0);
    step(0, 0, 0);
    chk("c2_if_valid", {31'b0, if_valid}, 32'd1);
    chk("c2_if_pc", if_pc, PC0);
    chk("c2_if_pc_plus4", if_pc_plus4, PC0 + 32'd4);
    chk("c2_instr_addr", instr_addr, PC0 + 32'd8);
  endtask

  initial begin
    n_assert    = 0;
    n_fail      = 0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    reset       = 1'b1;
    @(negedge clk);
    do_reset(1'b0);

    // latency-2 start-up
    basic_seq();

    // stall in cycles 4-6 with data returning
    step(0, 0, 0);
    step(0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0);

    // redirect to 80020030, then two bubbles
    step(0, 1, 32'h80020030);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("redir_if_valid", {31'b0, if_valid}, 32'd1);
    chk("redir_if_pc", if_pc, 32'h80020030);
    step(0, 0, 0);

    // redirect and stall together while the skid buffer is full
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 1, 32'h80020100);
    for (int i = 0; i < 4; i++) step(0, 0, 0);

    // mixed random stalls and occasional redirects
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) == 0)
        step($urandom_range(0, 1), 1, 32'h80030000 + ($urandom_range(0, 63) << 2));
      else
        step(($urandom_range(0, 2) == 0), 0, 0);
    end
    for (int i = 0; i < 3; i++) step(0, 0, 0);

    // reset during a stall with the skid buffer full, then replay start-up
    step(1, 0, 0);
    step(1, 0, 0);
    do_reset(1'b1);
    basic_seq();
    for (int i = 0; i < 3; i++) step(0, 0, 0);

    // redirect to 0: halt, stall first to show halting waits for stall=0
    step(0, 1, 32'h0);
    step(1, 0, 0);
    step(0, 0, 0);
    chk("halt_set", {31'b0, halted}, 32'd1);
    step(0, 1, PC0);
    step(1, 1, PC0);
    for (int i = 0; i < 3; i++) step(0, 0, 0);
    chk("halt_addr", instr_addr, 32'h0);
    chk("sb_drained", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
